// File: rtl/sssp_edge_expander.sv
// -----------------------------------------------------------------------------
// sssp_edge_expander
//
// Purpose:
//   Read-only edge-expansion stage for SSSP. For each accepted parent task it
//   fetches the node's CSR offset pair, streams the neighbor array in bursts of
//   at most MAX_BURST 64-bit words and emits one child task per edge through a
//   credit-managed response FIFO. Child timestamps saturate at all-ones.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   task_in_valid/ready          parent task handshake
//   in_task_ts/object/ttype      parent task fields
//   in_cq_slot                   parent CQ slot (copied to every child)
//   arvalid/arready/araddr/      read request channel (arsize fixed at 3,
//   arsize/arlen                 arlen = beats - 1)
//   rvalid/rready/rdata          read data channel, in-order responses
//   out_valid/out_ready          child task handshake
//   out_task_ts/object/ttype     child task fields
//   out_cq_slot, out_last        parent slot, final child of the parent
//   done_valid, done_count       one-cycle completion pulse + children emitted
//   err_degree                   sticky, set when a node has end < start
//   reg_wen/reg_waddr/reg_wdata  config writes: addr 12 -> offset_base,
//                                addr 16 -> nbr_base (both wdata << 2)
//
// TILE_ID only identifies the tile instance for debug purposes.
// -----------------------------------------------------------------------------
module sssp_edge_expander #(
  parameter int unsigned TILE_ID    = 0,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned TTYPE_W    = 4,
  parameter int unsigned SLOT_W     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  // parent task
  input  logic                task_in_valid,
  output logic                task_in_ready,
  input  logic [TS_WIDTH-1:0] in_task_ts,
  input  logic [31:0]         in_task_object,
  input  logic [TTYPE_W-1:0]  in_task_ttype,
  input  logic [SLOT_W-1:0]   in_cq_slot,
  // read request
  output logic                arvalid,
  input  logic                arready,
  output logic [31:0]         araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  // read data
  input  logic                rvalid,
  output logic                rready,
  input  logic [63:0]         rdata,
  // child task
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TS_WIDTH-1:0] out_task_ts,
  output logic [31:0]         out_task_object,
  output logic [TTYPE_W-1:0]  out_task_ttype,
  output logic [SLOT_W-1:0]   out_cq_slot,
  output logic                out_last,
  // completion / status
  output logic                done_valid,
  output logic [31:0]         done_count,
  output logic                err_degree,
  // configuration bus
  input  logic                reg_wen,
  input  logic [15:0]         reg_waddr,
  input  logic [31:0]         reg_wdata
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LW = $clog2(MAX_BURST + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = ((TS_WIDTH > 32) ? TS_WIDTH : 32) + 1;

  typedef enum logic [2:0] {
    IDLE,
    OFF_REQ,
    OFF_WAIT,
    NBR_REQ,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          obj_q, obj_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [TTYPE_W-1:0]   ttype_q, ttype_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [31:0]          cur_q, cur_d;
  logic [31:0]          rem_q, rem_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        occ_q, occ_d;
  logic [31:0]          count_q, count_d;
  logic                 err_q, err_d;
  logic [31:0]          offset_base_q, nbr_base_q;
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [63:0]          mem_q [FIFO_DEPTH];

  logic                 push, pop;
  logic [LW-1:0]        burstLen;
  logic [CW-1:0]        credits;
  logic [CW-1:0]        issueLen;
  logic [63:0]          head;
  logic [SW-1:0]        tsSum;
  logic [31:0]          offStart, offEnd;

  assign arsize   = 3'd3;
  assign offStart = rdata[31:0];
  assign offEnd   = rdata[63:32];

  // Burst length is capped by MAX_BURST; credits count FIFO slots that are
  // neither occupied nor already promised to beats still in flight, so a
  // request is only issued when every beat it returns has a guaranteed slot.
  assign burstLen = (rem_q > MAX_BURST) ? LW'(MAX_BURST) : LW'(rem_q);
  assign credits  = CW'(FIFO_DEPTH) - occ_q - outst_q;

  // The FIFO head is the child at the output; the timestamp add is done one
  // bit wider than the timestamp so overflow can be detected and clamped.
  assign head      = mem_q[rptr_q];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign tsSum     = SW'(ts_q) + SW'(head[63:32]);

  assign out_task_object = head[31:0];
  assign out_task_ts     = (tsSum > SW'({TS_WIDTH{1'b1}})) ? {TS_WIDTH{1'b1}}
                                                          : tsSum[TS_WIDTH-1:0];
  assign out_task_ttype  = ttype_q;
  assign out_cq_slot     = slot_q;

  // The final child is the last buffered entry once no more beats can arrive.
  assign out_last   = (rem_q == '0) && (outst_q == '0) && (occ_q == CW'(1));
  assign done_count = done_valid ? count_q : '0;
  assign err_degree = err_q;

  // Control FSM: next state, request channel, read acceptance and
  // bookkeeping of the task currently being expanded.
  always_comb begin
    state_d       = state_q;
    obj_d         = obj_q;
    ts_d          = ts_q;
    ttype_d       = ttype_q;
    slot_d        = slot_q;
    cur_d         = cur_q;
    rem_d         = rem_q;
    count_d       = count_q;
    err_d         = err_q;
    task_in_ready = 1'b0;
    arvalid       = 1'b0;
    araddr        = '0;
    arlen         = '0;
    rready        = 1'b0;
    push          = 1'b0;
    issueLen      = '0;
    done_valid    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted.
        task_in_ready = rstn;
        if (task_in_valid && rstn) begin
          obj_d   = in_task_object;
          ts_d    = in_task_ts;
          ttype_d = in_task_ttype;
          slot_d  = in_cq_slot;
          cur_d   = '0;
          rem_d   = '0;
          count_d = '0;
          state_d = OFF_REQ;
        end
      end

      OFF_REQ: begin
        // The 8-byte read at a 4-byte stride returns offsets[obj] and
        // offsets[obj+1] together as {end, start}.
        arvalid = 1'b1;
        araddr  = offset_base_q + (obj_q << 2);
        if (arready) state_d = OFF_WAIT;
      end

      OFF_WAIT: begin
        rready = 1'b1;
        if (rvalid) begin
          if (offEnd > offStart) begin
            cur_d   = offStart;
            rem_d   = offEnd - offStart;
            state_d = NBR_REQ;
          end else begin
            state_d = DRAIN;
          end
          if (offEnd < offStart) err_d = 1'b1;
        end
      end

      NBR_REQ: begin
        rready  = 1'b1;
        push    = rvalid;
        araddr  = nbr_base_q + (cur_q << 3);
        arlen   = 8'(burstLen - LW'(1));
        arvalid = (credits >= CW'(burstLen));
        if (arvalid && arready) begin
          issueLen = CW'(burstLen);
          cur_d    = cur_q + 32'(burstLen);
          rem_d    = rem_q - 32'(burstLen);
          if (rem_q == 32'(burstLen)) state_d = DRAIN;
        end
      end

      DRAIN: begin
        rready = 1'b1;
        push   = rvalid;
        if ((occ_q == '0) && (outst_q == '0)) begin
          done_valid = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (pop) count_d = count_q + 32'd1;
  end

  // Every data beat moves one unit from "outstanding" into the FIFO; a
  // simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    outst_d = outst_q + issueLen - CW'(push);
    occ_d   = occ_q + CW'(push) - CW'(pop);
  end

  // Control and datapath registers; configuration writes are accepted in
  // any state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      obj_q         <= '0;
      ts_q          <= '0;
      ttype_q       <= '0;
      slot_q        <= '0;
      cur_q         <= '0;
      rem_q         <= '0;
      outst_q       <= '0;
      occ_q         <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      offset_base_q <= '0;
      nbr_base_q    <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      state_q <= state_d;
      obj_q   <= obj_d;
      ts_q    <= ts_d;
      ttype_q <= ttype_d;
      slot_q  <= slot_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      occ_q   <= occ_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (reg_wen && (reg_waddr == 16'd12)) offset_base_q <= reg_wdata << 2;
      if (reg_wen && (reg_waddr == 16'd16)) nbr_base_q    <= reg_wdata << 2;
      if (push) wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
  end

  // FIFO storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rdata;
  end

endmodule

// File: tb/tb_sssp_edge_expander.sv
// -----------------------------------------------------------------------------
// tb_sssp_edge_expander
//
// Directed bench for sssp_edge_expander. A memory model answers read bursts
// from a 32-bit word array holding a CSR offset table (offset_base = 0x400)
// and an edge array of {weight, object} words (nbr_base = 0x1000). Expected
// values are hand-computed from the stimulus tables below.
// -----------------------------------------------------------------------------
module tb_sssp_edge_expander;

  localparam int          FIFO_DEPTH = 16;
  localparam logic [31:0] OFF_BASE   = 32'h400;
  localparam logic [31:0] NBR_BASE   = 32'h1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        task_in_valid = 1'b0;
  logic        task_in_ready;
  logic [31:0] in_task_ts = '0;
  logic [31:0] in_task_object = '0;
  logic [3:0]  in_task_ttype = '0;
  logic [7:0]  in_cq_slot = '0;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_task_ts, out_task_object;
  logic [3:0]  out_task_ttype;
  logic [7:0]  out_cq_slot;
  logic        out_last, done_valid, err_degree;
  logic [31:0] done_count;
  logic        reg_wen = 1'b0;
  logic [15:0] reg_waddr = '0;
  logic [31:0] reg_wdata = '0;

  always #5 clk = ~clk;

  sssp_edge_expander #(
    .TILE_ID(0), .MAX_BURST(16), .FIFO_DEPTH(FIFO_DEPTH), .TS_WIDTH(32),
    .TTYPE_W(4), .SLOT_W(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .task_in_valid(task_in_valid), .task_in_ready(task_in_ready),
    .in_task_ts(in_task_ts), .in_task_object(in_task_object),
    .in_task_ttype(in_task_ttype), .in_cq_slot(in_cq_slot),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arsize(arsize), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_task_ts(out_task_ts), .out_task_object(out_task_object),
    .out_task_ttype(out_task_ttype), .out_cq_slot(out_cq_slot),
    .out_last(out_last), .done_valid(done_valid), .done_count(done_count),
    .err_degree(err_degree),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
  );

  int compared = 0;
  int mismatched = 0;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Memory model storage (word index = byte address >> 2).
  logic [31:0] mem32 [0:2047];

  function automatic logic [63:0] memRead(input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
    if (idx < 0 || idx > 2046) return 64'hDEAD_DEAD_DEAD_DEAD;
    return {mem32[idx + 1], mem32[idx]};
  endfunction

  // Monitor / responder state
  int          cycle = 0;
  logic [31:0] beatQ[$];
  logic [31:0] arAddrLog[$];
  logic [7:0]  arLenLog[$];
  logic [31:0] childObj[$];
  logic [31:0] childTs[$];
  logic        childLast[$];
  int          childCycle[$];
  logic [3:0]  lastChildType;
  logic [7:0]  lastChildSlot;
  int          doneEvents = 0;
  logic [31:0] lastDoneCount = '0;
  int          doneCycle = 0;
  int          offBeatCycle = 0;
  int          nbrInFlight = 0;
  int          maxInFlight = 0;
  logic        outReadyCtl = 1'b1;

  // Inputs change on the falling edge; handshakes are evaluated 1 ns later,
  // where they are stable until the next rising edge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; out_ready = 1'b0;
    lastChildType = '0; lastChildSlot = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rstn) begin
        beatQ.delete();
        nbrInFlight = 0;
      end
      arready   = 1'b1;
      out_ready = outReadyCtl;
      rvalid    = rstn && (beatQ.size() > 0);
      rdata     = rvalid ? memRead(beatQ[0]) : 64'h0;
      #1;
      if (rstn) begin
        if (arvalid && arready) begin
          arAddrLog.push_back(araddr);
          arLenLog.push_back(arlen);
          for (int b = 0; b <= int'(arlen); b++) beatQ.push_back(araddr + 32'(8 * b));
          if (araddr >= NBR_BASE) nbrInFlight += int'(arlen) + 1;
        end
        if (rvalid && rready) begin
          if (beatQ[0] < NBR_BASE) offBeatCycle = cycle;
          void'(beatQ.pop_front());
        end
        if (out_valid && out_ready) begin
          childObj.push_back(out_task_object);
          childTs.push_back(out_task_ts);
          childLast.push_back(out_last);
          childCycle.push_back(cycle);
          lastChildType = out_task_ttype;
          lastChildSlot = out_cq_slot;
          nbrInFlight--;
        end
        if (nbrInFlight > maxInFlight) maxInFlight = nbrInFlight;
        if (done_valid) begin
          doneEvents++;
          lastDoneCount = done_count;
          doneCycle = cycle;
        end
      end
    end
  end

  task automatic regWrite(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    reg_wen = 1'b1; reg_waddr = addr; reg_wdata = data;
    @(negedge clk);
    reg_wen = 1'b0;
  endtask

  task automatic setOffsets(input int node, input int startIdx, input int endIdx);
    mem32[256 + node]     = 32'(startIdx);
    mem32[256 + node + 1] = 32'(endIdx);
  endtask

  task automatic setEdge(input int idx, input logic [31:0] obj, input logic [31:0] w);
    mem32[1024 + 2 * idx]     = obj;
    mem32[1024 + 2 * idx + 1] = w;
  endtask

  // Presents one parent task and waits for its acceptance; checks that the
  // offset request appears the cycle after acceptance.
  task automatic applyStimulus(input logic [31:0] obj, input logic [31:0] ts);
    int guard;
    guard = 0;
    arAddrLog.delete(); arLenLog.delete();
    childObj.delete(); childTs.delete(); childLast.delete(); childCycle.delete();
    doneEvents = 0; maxInFlight = 0;
    @(negedge clk);
    task_in_valid = 1'b1; in_task_object = obj; in_task_ts = ts;
    in_task_ttype = 4'h5; in_cq_slot = 8'hA3;
    #2;
    while (!task_in_ready && guard < 100) begin
      @(negedge clk); #2; guard++;
    end
    checkOutput("task_accept", 64'(guard < 100), 64'd1);
    @(negedge clk); #2;
    task_in_valid = 1'b0;
    checkOutput("arvalid_T1", 64'(arvalid), 64'd1);
  endtask

  task automatic waitDone(input int budget);
    int guard;
    guard = 0;
    while (doneEvents == 0 && guard < budget) begin
      @(negedge clk); #2; guard++;
    end
    checkOutput("done_seen", 64'(doneEvents), 64'd1);
  endtask

  int bad;
  int lastCnt;

  initial begin
    for (int i = 0; i < 2048; i++) mem32[i] = '0;

    // ---- reset values
    #2;
    checkOutput("rst_task_in_ready", 64'(task_in_ready), 64'd0);
    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_rready", 64'(rready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_done", 64'({done_valid, done_count}), 64'd0);
    checkOutput("rst_err_degree", 64'(err_degree), 64'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("ready_after_reset", 64'(task_in_ready), 64'd1);

    regWrite(16'd12, 32'h100);
    regWrite(16'd16, 32'h400);

    // ---- node 3: offsets (10,13), three edges, parent ts 100
    setOffsets(3, 10, 13);
    setEdge(10, 32'd5, 32'd2);
    setEdge(11, 32'd7, 32'd4);
    setEdge(12, 32'd9, 32'd1);
    applyStimulus(32'd3, 32'd100);
    checkOutput("arsize", 64'(arsize), 64'd3);
    waitDone(200);
    checkOutput("n3_ar_count", 64'(arAddrLog.size()), 64'd2);
    if (arAddrLog.size() == 2) begin
      checkOutput("n3_off_addr", 64'(arAddrLog[0]), 64'h40C);
      checkOutput("n3_off_len", 64'(arLenLog[0]), 64'd0);
      checkOutput("n3_nbr_addr", 64'(arAddrLog[1]), 64'h1050);
      checkOutput("n3_nbr_len", 64'(arLenLog[1]), 64'd2);
    end
    checkOutput("n3_child_count", 64'(childObj.size()), 64'd3);
    if (childObj.size() == 3) begin
      checkOutput("n3_c0", {childObj[0], childTs[0]}, {32'd5, 32'd102});
      checkOutput("n3_c1", {childObj[1], childTs[1]}, {32'd7, 32'd104});
      checkOutput("n3_c2", {childObj[2], childTs[2]}, {32'd9, 32'd101});
      checkOutput("n3_last", 64'({childLast[0], childLast[1], childLast[2]}), 64'b001);
      checkOutput("n3_done_timing", 64'(doneCycle - childCycle[2]), 64'd1);
    end
    checkOutput("n3_done_count", 64'(lastDoneCount), 64'd3);
    checkOutput("n3_child_fields", 64'({lastChildType, lastChildSlot}), 64'h5A3);
    @(negedge clk); #2;
    checkOutput("n3_ready_after_done", 64'(task_in_ready), 64'd1);

    // ---- node 7: degree 40 split into 16/16/8
    setOffsets(7, 50, 90);
    for (int k = 0; k < 40; k++) setEdge(50 + k, 32'(1000 + k), 32'(k));
    applyStimulus(32'd7, 32'd500);
    waitDone(400);
    checkOutput("d40_ar_count", 64'(arAddrLog.size()), 64'd4);
    if (arAddrLog.size() == 4) begin
      checkOutput("d40_b0", {arAddrLog[1], 24'd0, arLenLog[1]}, {NBR_BASE + 32'd400, 32'd15});
      checkOutput("d40_b1", {arAddrLog[2], 24'd0, arLenLog[2]}, {NBR_BASE + 32'd528, 32'd15});
      checkOutput("d40_b2", {arAddrLog[3], 24'd0, arLenLog[3]}, {NBR_BASE + 32'd656, 32'd7});
    end
    checkOutput("d40_child_count", 64'(childObj.size()), 64'd40);
    bad = 0; lastCnt = 0;
    foreach (childObj[k]) begin
      if (childObj[k] !== 32'(1000 + k) || childTs[k] !== 32'(500 + k)) bad++;
      if (childLast[k]) lastCnt++;
    end
    checkOutput("d40_order_bad", 64'(bad), 64'd0);
    checkOutput("d40_one_last", 64'(lastCnt), 64'd1);
    if (childLast.size() == 40) checkOutput("d40_last_pos", 64'(childLast[39]), 64'd1);
    checkOutput("d40_done_count", 64'(lastDoneCount), 64'd40);

    // ---- node 5: zero degree
    setOffsets(5, 20, 20);
    applyStimulus(32'd5, 32'd7);
    waitDone(100);
    checkOutput("z_ar_count", 64'(arAddrLog.size()), 64'd1);
    checkOutput("z_child_count", 64'(childObj.size()), 64'd0);
    checkOutput("z_done_timing", 64'(doneCycle - offBeatCycle), 64'd1);
    checkOutput("z_done_count", 64'(lastDoneCount), 64'd0);
    checkOutput("z_err_degree", 64'(err_degree), 64'd0);

    // ---- node 6: end < start
    setOffsets(6, 30, 20);
    applyStimulus(32'd6, 32'd7);
    waitDone(100);
    checkOutput("neg_child_count", 64'(childObj.size()), 64'd0);
    checkOutput("neg_err_degree", 64'(err_degree), 64'd1);
    checkOutput("neg_done_count", 64'(lastDoneCount), 64'd0);

    // ---- node 8: timestamp saturation
    setOffsets(8, 100, 103);
    setEdge(100, 32'd11, 32'h20);
    setEdge(101, 32'd12, 32'h5);
    setEdge(102, 32'd13, 32'hF);
    applyStimulus(32'd8, 32'hFFFF_FFF0);
    waitDone(200);
    checkOutput("sat_child_count", 64'(childObj.size()), 64'd3);
    if (childTs.size() == 3) begin
      checkOutput("sat_c0", 64'(childTs[0]), 64'hFFFF_FFFF);
      checkOutput("sat_c1", 64'(childTs[1]), 64'hFFFF_FFF5);
      checkOutput("sat_c2_exact", 64'(childTs[2]), 64'hFFFF_FFFF);
    end
    checkOutput("err_sticky", 64'(err_degree), 64'd1);

    // ---- node 9: degree 40 with out_ready held low for 50 cycles
    setOffsets(9, 200, 240);
    for (int k = 0; k < 40; k++) setEdge(200 + k, 32'(2000 + k), 32'(3 * k));
    outReadyCtl = 1'b0;
    applyStimulus(32'd9, 32'h1000);
    repeat (50) @(negedge clk);
    #2;
    checkOutput("bp_no_child", 64'(childObj.size()), 64'd0);
    checkOutput("bp_inflight_max", 64'(maxInFlight), 64'(FIFO_DEPTH));
    outReadyCtl = 1'b1;
    waitDone(400);
    checkOutput("bp_child_count", 64'(childObj.size()), 64'd40);
    bad = 0;
    foreach (childObj[k])
      if (childObj[k] !== 32'(2000 + k) || childTs[k] !== 32'(32'h1000 + 3 * k)) bad++;
    checkOutput("bp_order_bad", 64'(bad), 64'd0);
    checkOutput("bp_inflight_bound", 64'(maxInFlight <= FIFO_DEPTH), 64'd1);

    // ---- reset in the middle of a burst, then a fresh task
    setOffsets(7, 50, 90);
    applyStimulus(32'd7, 32'd500);
    bad = 0;
    while (childObj.size() < 5 && bad < 200) begin
      @(negedge clk); bad++;
    end
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_outputs",
                64'({task_in_ready, arvalid, rready, out_valid, out_last, done_valid, err_degree}),
                64'd0);
    checkOutput("mid_rst_done_count", 64'(done_count), 64'd0);
    repeat (2) @(negedge clk);
    #3;
    rstn = 1'b1;
    regWrite(16'd12, 32'h100);
    regWrite(16'd16, 32'h400);
    setOffsets(3, 10, 13);
    applyStimulus(32'd3, 32'd100);
    waitDone(200);
    checkOutput("post_rst_child_count", 64'(childObj.size()), 64'd3);
    if (childObj.size() == 3)
      checkOutput("post_rst_c2", {childObj[2], childTs[2]}, {32'd9, 32'd101});
    checkOutput("post_rst_done_count", 64'(lastDoneCount), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sssp_edge_expander.md
# sssp_edge_expander

Multi-cycle, parametrised successor to the SSSP read-only edge-expansion stage. For one accepted task it:
- reads the node's offset pair;
- streams the neighbor array in bursts of at most MAX_BURST words;
- emits one child task per edge through a credit-managed response FIFO.

Compared with the single-cycle subtype scheme, it adds burst splitting for high-degree nodes, FIFO backpressure, saturating timestamps, last-child marking and a per-task completion pulse. It sits between the RO dispatch and the child-enqueue port of a tile.

## Interface
- TILE_ID, 0, tile index (debug print only)
- MAX_BURST, 16, max words per neighbor read burst (1..256)
- FIFO_DEPTH, 16, response FIFO entries; must be >= MAX_BURST, power of two
- TS_WIDTH, 32, timestamp width used for the saturating add
- clk  in  1  clock; one clock domain
- rstn  in  1  reset, asynchronous, active-low
- task_in_valid / task_in_ready  in/out  1  parent task handshake
- in_task  in  task_t  parent task (ts, object, ttype)
- in_cq_slot  in  cq_slice_slot_t  parent CQ slot
- arvalid / arready  out/in  1  read request handshake
- araddr  out  32  byte address
- arsize  out  3  always 3 (8-byte words)
- arlen  out  8  beats minus one
- rvalid / rready  in/out  1  read data handshake, in-order responses
- rdata  in  64  read data
- out_valid / out_ready  out/in  1  child task handshake
- out_task  out  task_t  child: object = edge[31:0], ts = sat(parent.ts + edge[63:32]), ttype = parent's
- out_cq_slot  out  cq_slice_slot_t  parent's slot
- out_last  out  1  final child of the current parent
- done_valid  out  1  one-cycle pulse when the parent is fully expanded
- done_count  out  32  children emitted for that parent
- err_degree  out  1  sticky; set when end < start
- reg_bus  –  reg_bus_t  config; write addr 12: offset_base = wdata<<2; addr 16: nbr_base = wdata<<2

## Operation
- States: IDLE, OFF_REQ, OFF_WAIT, NBR_REQ, DRAIN.
- IDLE:
  - task_in_ready=1.
  - On accept, latch task and slot, clear the child counter, go to OFF_REQ.
- OFF_REQ:
  - Drive arvalid, araddr = offset_base + (object<<2), arlen=0.
  - On arready, go to OFF_WAIT.
- OFF_WAIT:
  - rready=1. On rvalid: start = rdata[31:0], end = rdata[63:32].
  - If end > start: cur = start, remaining = end - start, go to NBR_REQ.
  - Otherwise go to DRAIN with no children.
  - end < start additionally sets err_degree.
- NBR_REQ:
  - len = min(remaining, MAX_BURST), araddr = nbr_base + (cur<<3), arlen = len-1.
  - arvalid only when credits >= len, where credits = FIFO_DEPTH − occupancy − outstanding beats.
  - On handshake: cur += len, remaining −= len, outstanding += len.
  - Go to DRAIN when remaining reaches 0.
  - Later bursts may issue before earlier data returns.
- rready is 1 in NBR_REQ and DRAIN. Credits guarantee space, so the FIFO never overflows. Each beat pushes and decrements outstanding.
- Child output:
  - FIFO head drives out_valid.
  - Timestamp add is TS_WIDTH+1 bits; results above 2^TS_WIDTH−1 clamp to all-ones.
  - out_last = 1 when remaining=0, outstanding=0 and occupancy=1.
- DRAIN: when FIFO is empty and outstanding is 0, pulse done_valid with done_count, go to IDLE.
- reg_bus writes are honoured in any state. Changing a base while busy is undefined.

## Timing
- Reset values:
  - state=IDLE.
  - task_in_ready=0 during reset, 1 in the first cycle after deassertion.
  - arvalid=0, rready=0, out_valid=0, out_last=0, done_valid=0, done_count=0, err_degree=0.
  - FIFO empty, counters 0, bases 0.
- Task accepted at cycle T:
  - arvalid at T+1.
  - Earliest NBR_REQ at one cycle after the offset beat.
- FIFO is fall-through: a child is visible on out_valid the cycle after its beat is pushed.
  - One child per cycle with out_ready held high.
  - Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- done_valid fires the cycle after the last child handshake, or the cycle after the offset beat for a zero-degree node.
- Back-to-back: task_in_ready reasserts the cycle after done_valid.
- arvalid, araddr and arlen stay stable until arready. out_* stays stable until out_ready.
- Asynchronous reset mid-operation: all state drops to reset values immediately. In-flight responses are discarded, and the memory system is reset alongside.

## Test plan
- Node 3, offsets (10,13), edges {(5,w2),(7,w4),(9,w1)}, parent ts=100 -> one burst arlen=2 at nbr_base+80; children (5,102),(7,104),(9,101); out_last on the third; done_count=3.
- Degree 40, MAX_BURST=16 -> bursts of lengths 16,16,8 at cur=start, start+16, start+32; 40 children in order; exactly one out_last.
- Zero degree (start=end=20) -> no neighbor request; done_valid one cycle after the offset beat with done_count=0; err_degree stays 0.
- end < start (30,20) -> no children, err_degree=1 and sticky; done_valid pulses.
- ts=0xFFFFFFF0, weight 0x20 -> child ts=0xFFFFFFFF. Separately, out_ready=0 for 50 cycles with degree 40 -> at most FIFO_DEPTH beats outstanding plus buffered, no loss, order preserved.
- Reset asserted mid-burst -> all outputs at reset values within the same cycle; a new task after deassertion completes normally.
